program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a 16-bit word count followed by that many
// 16-bit words (high byte first) and writes them to instruction memory starting at
// address 0, holding the CPU in reset until a load completes successfully.
module program_loader #(
    parameter int unsigned OPERAND_WIDTH     = 11,
    parameter int unsigned INSTRUCTION_WIDTH = 16
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid_in,
    output logic                         byte_ready_out,
    output logic [OPERAND_WIDTH-1:0]     imem_address_out,
    output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
    output logic                         imem_wr_out,
    output logic                         cpu_hold_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out
);

    // Counter is one bit wider than the address so a full-memory load (N = 2^OPERAND_WIDTH)
    // can reach its terminal count without wrapping.
    localparam int unsigned CNT_W     = OPERAND_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << OPERAND_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StDone,
        StError
    } state_t;

    state_t                         r_state;
    logic [CNT_W-1:0]               r_count;
    logic [15:0]                    r_len;
    logic [7:0]                     r_hi_byte;
    logic [OPERAND_WIDTH-1:0]       r_imem_addr;
    logic [INSTRUCTION_WIDTH-1:0]   r_imem_data;
    logic                           r_imem_wr;

    logic                           w_ready;
    logic                           w_accept;
    logic [15:0]                    w_word;
    logic [CNT_W-1:0]               w_cnt_next;

    assign w_ready    = (r_state == StLenHi) || (r_state == StLenLo) ||
                        (r_state == StDataHi) || (r_state == StDataLo);
    assign w_accept   = w_ready && byte_valid_in;
    assign w_word     = {r_hi_byte, byte_in};
    assign w_cnt_next = r_count + CNT_W'(1);

    // Load sequencer: parses the stream and issues one registered write per word.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_len       <= '0;
            r_hi_byte   <= '0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_imem_wr   <= 1'b0;
        end else begin
            r_imem_wr <= 1'b0;
            case (r_state)
                StIdle, StDone, StError: begin
                    if (start_in) begin
                        r_state <= StLenHi;
                        r_count <= '0;
                    end
                end
                StLenHi: begin
                    if (w_accept) begin
                        r_hi_byte <= byte_in;
                        r_state   <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (w_accept) begin
                        r_len <= w_word;
                        if (w_word == 16'd0) begin
                            r_state <= StDone;
                        end else if (32'(w_word) > MAX_WORDS) begin
                            r_state <= StError;
                        end else begin
                            r_state <= StDataHi;
                        end
                    end
                end
                StDataHi: begin
                    if (w_accept) begin
                        r_hi_byte <= byte_in;
                        r_state   <= StDataLo;
                    end
                end
                StDataLo: begin
                    if (w_accept) begin
                        r_imem_wr   <= 1'b1;
                        r_imem_addr <= r_count[OPERAND_WIDTH-1:0];
                        r_imem_data <= INSTRUCTION_WIDTH'(w_word);
                        r_state     <= StWrite;
                    end
                end
                StWrite: begin
                    r_count <= w_cnt_next;
                    if (32'(w_cnt_next) == 32'(r_len)) begin
                        r_state <= StDone;
                    end else begin
                        r_state <= StDataHi;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign byte_ready_out   = w_ready;
    assign imem_address_out = r_imem_addr;
    assign imem_data_out    = r_imem_data;
    assign imem_wr_out      = r_imem_wr;
    assign cpu_hold_out     = (r_state != StDone);
    assign busy_out         = w_ready || (r_state == StWrite);
    assign done_out         = (r_state == StDone);
    assign error_out        = (r_state == StError);

endmodule
